hls_deadlock_reporter: RTL and testbench
========================================

Name: hls_deadlock_reporter

Overview:
- Sits directly downstream of the per-instance HLS deadlock monitors in the SimpleTxMCDMA debug path.
- Consumes their one-bit `block` outputs and qualifies a block as a deadlock only after it persists for a programmable number of consecutive cycles.
- Latches which monitor fired and when, then presents one report record over a valid/ready handshake.
- Holds a sticky deadlock flag until software or the test bench clears it.

Parameters:
- NUM_MON, 4, number of monitor `block` inputs (>=1).
- THRESHOLD, 16, consecutive blocked cycles required to declare deadlock (2 <= THRESHOLD < 2^CNT_W).
- CNT_W, 32, width of the timestamp and stall counters.
- IDX_W, clog2(NUM_MON) with minimum 1, source index width (derived).

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- block_in  in  NUM_MON  per-monitor block flags, level-sensitive.
- clr  in  1  one-cycle clear request; returns the block to IDLE.
- deadlock  out  1  sticky deadlock indication.
- report_valid  out  1  report record available.
- report_ready  in  1  consumer accepts the record.
- report_data  out  IDX_W+CNT_W  {src_idx, first_block_timestamp}.
- deadlock_count  out  8  saturating count of declared deadlocks.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ts_q, stall_cnt, src_q, ts_cap, deadlock_count = 0.
  - deadlock=0, report_valid=0, report_data=0.
  - Assertion mid-operation aborts any report with no handshake.
- Timestamp:
  - ts_q increments by 1 every cycle and wraps modulo 2^CNT_W.
  - It never stops or clears, except on reset.
- States:
  - IDLE:
    - If any block_in bit is 1, latch src_q = lowest set index, ts_cap = ts_q, stall_cnt = 1.
    - Then go to SUSPECT.
  - SUSPECT:
    - Only block_in[src_q] is observed; other bits are ignored.
    - If block_in[src_q]=0: stall_cnt=0, go to IDLE.
    - Otherwise stall_cnt+1. When the incremented value equals THRESHOLD, go to REPORT and increment deadlock_count, saturating at 255.
  - REPORT:
    - deadlock=1, report_valid=1, report_data={src_q, ts_cap}.
    - report_data is held stable while report_ready=0.
    - On valid&&ready, go to HOLD; report_valid drops the next cycle.
  - HOLD:
    - deadlock=1, report_valid=0.
    - The block_in value is ignored.
- Latency: if block_in[k] is sampled high on THRESHOLD consecutive edges, report_valid and deadlock rise in the cycle after the THRESHOLD-th edge.
- Outputs are registered, with no combinational path from inputs to outputs.
- clr:
  - Highest priority in every state: next state is IDLE, stall_cnt=0, deadlock=0, report_valid=0.
  - clr and valid&&ready in the same cycle: the handshake counts as completed and the state still goes to IDLE.
  - clr in IDLE is a no-op. A block_in bit high in the clr cycle is not latched; detection restarts the following cycle.
  - deadlock_count is not cleared by clr; only reset clears it.
- After a clear, a block that is still asserted is detected again after THRESHOLD more cycles. This gives a new report with a new timestamp.
- ts wrap between capture and report is harmless: ts_cap is captured once.

Decomposition:
- Shared package hls_dbg_pkg:
  - state enum {IDLE, SUSPECT, REPORT, HOLD}.
  - clog2-based IDX_W function.
  - Report record typedef {src_idx, timestamp}.
- One natural sub-module: hls_dbg_prio_enc, an NUM_MON-input lowest-index priority encoder returning the index and an any-set flag.

Test Plan:
- All tests use NUM_MON=4, THRESHOLD=16, CNT_W=32.
- Basic detection: block_in=4'b0100 first sampled high when ts_q=10, held for 20 cycles -> report_valid=1 and deadlock=1 starting the cycle after the 16th high edge; report_data={2'd2, 32'd10}; deadlock_count=1.
- Glitch rejection: block_in[1] high for 15 cycles, then low -> no report_valid; deadlock=0; state returns to IDLE; deadlock_count=0.
- Priority: block_in=4'b1010 asserted simultaneously from IDLE -> src_idx=1. Bit 3 then drops and bit 1 is held 16 cycles -> report with src_idx=1. Separately, bit 1 drops at cycle 5 while bit 3 stays high -> return to IDLE, then re-detect src=3 with a new timestamp.
- Backpressure: report_ready=0 for 5 cycles after valid -> report_data is unchanged each cycle. Then ready=1 for one cycle -> report_valid=0 the next cycle, deadlock stays 1. clr pulse -> deadlock=0 the next cycle.
- Clear races:
  - clr during SUSPECT at stall_cnt=8 -> no report; a held block reports 16 cycles after clr.
  - clr coincident with valid&&ready -> IDLE; deadlock_count unchanged.
- Reset mid-operation and saturation:
  - reset=0 asynchronously during REPORT -> all outputs 0 immediately, without a clock edge.
  - 300 detect/clr cycles -> deadlock_count=255.

Source files
------------

// File: rtl/hls_dbg_pkg.sv
// Shared types and helpers for the HLS deadlock debug path.
package hls_dbg_pkg;

    typedef enum logic [1:0] {IDLE, SUSPECT, REPORT, HOLD} dbg_state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_MON = 4;
    localparam int DEF_CNT_W   = 32;

    // Report record at the default configuration, for consumers of report_data.
    typedef struct packed {
        logic [idx_w(DEF_NUM_MON)-1:0] src_idx;
        logic [DEF_CNT_W-1:0]          timestamp;
    } report_rec_t;

endpackage

// File: rtl/hls_dbg_prio_enc.sv
// Lowest-index priority encoder over the monitor block flags.
module hls_dbg_prio_enc import hls_dbg_pkg::*; #(
    parameter  int NUM_MON = 4,
    localparam int IDX_W   = idx_w(NUM_MON)
) (
    input  logic [NUM_MON-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hls_deadlock_reporter.sv
// Qualifies persistent HLS monitor blocks as deadlocks and emits one report record each.
module hls_deadlock_reporter import hls_dbg_pkg::*; #(
    parameter  int NUM_MON   = 4,
    parameter  int THRESHOLD = 16,
    parameter  int CNT_W     = 32,
    localparam int IDX_W     = idx_w(NUM_MON)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MON-1:0]     block_in,
    input  logic                   clr,
    output logic                   deadlock,
    output logic                   report_valid,
    input  logic                   report_ready,
    output logic [IDX_W+CNT_W-1:0] report_data,
    output logic [7:0]             deadlock_count
);

    typedef struct packed {
        logic [IDX_W-1:0] src_idx;
        logic [CNT_W-1:0] timestamp;
    } report_t;

    dbg_state_t       state_q, state_d;
    logic [CNT_W-1:0] ts_q, ts_cap, stall_cnt, stall_inc;
    logic [IDX_W-1:0] src_q, enc_idx;
    logic             enc_any, latch, fire;
    report_t          rec_q;

    hls_dbg_prio_enc #(.NUM_MON(NUM_MON)) u_enc (
        .req (block_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign stall_inc   = stall_cnt + CNT_W'(1);
    assign report_data = rec_q;

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        fire    = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enc_any) begin
                        state_d = SUSPECT;
                        latch   = 1'b1;
                    end
                end
                SUSPECT: begin
                    // Only the latched source matters until it drops or qualifies.
                    if (!block_in[src_q]) begin
                        state_d = IDLE;
                    end else if (stall_inc == CNT_W'(THRESHOLD)) begin
                        state_d = REPORT;
                        fire    = 1'b1;
                    end
                end
                REPORT: begin
                    if (report_ready) state_d = HOLD;
                end
                HOLD: state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q           <= '0;
            ts_cap         <= '0;
            stall_cnt      <= '0;
            src_q          <= '0;
            rec_q          <= '0;
            deadlock       <= 1'b0;
            report_valid   <= 1'b0;
            deadlock_count <= '0;
        end else begin
            ts_q <= ts_q + CNT_W'(1);
            if (state_d == IDLE)          stall_cnt <= '0;
            else if (latch)               stall_cnt <= CNT_W'(1);
            else if (state_q == SUSPECT)  stall_cnt <= stall_inc;
            if (latch) begin
                src_q  <= enc_idx;
                ts_cap <= ts_q;
            end
            if (fire) begin
                rec_q <= '{src_idx: src_q, timestamp: ts_cap};
                if (deadlock_count != 8'hFF) deadlock_count <= deadlock_count + 8'd1;
            end
            deadlock     <= (state_d == REPORT) || (state_d == HOLD);
            report_valid <= (state_d == REPORT);
        end
    end

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Randomized scoreboard bench for hls_deadlock_reporter against a streak-based reference model.
module tb_hls_deadlock_reporter;

    localparam int THR = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  block_in = '0;
    logic        clr = 1'b0;
    logic        report_ready = 1'b0;
    logic        deadlock, report_valid;
    logic [33:0] report_data;
    logic [7:0]  deadlock_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model: which source is being watched, how long its streak is,
    // and whether a deadlock has been flagged / its report accepted.
    int          m_src;
    int          m_streak;
    logic [31:0] m_start;
    logic [31:0] m_ts;
    bit          m_flag, m_acked;
    int          m_count;
    logic [33:0] sb[$];

    hls_deadlock_reporter #(.NUM_MON(4), .THRESHOLD(THR), .CNT_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .block_in       (block_in),
        .clr            (clr),
        .deadlock       (deadlock),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_data    (report_data),
        .deadlock_count (deadlock_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_src = -1; m_streak = 0; m_start = '0; m_ts = '0;
        m_flag = 0; m_acked = 0; m_count = 0;
        sb.delete();
    endtask

    task automatic model_edge(input logic [3:0] b, input logic c, input logic r);
        if (c) begin
            if (m_flag && !m_acked && !r) void'(sb.pop_back());
            m_src = -1; m_streak = 0; m_flag = 0; m_acked = 0;
        end else if (m_flag) begin
            if (r) m_acked = 1;
        end else if (m_src < 0) begin
            for (int i = 3; i >= 0; i--) if (b[i]) m_src = i;
            if (m_src >= 0) begin
                m_start  = m_ts;
                m_streak = 1;
            end
        end else if (!b[m_src]) begin
            m_src = -1; m_streak = 0;
        end else begin
            m_streak++;
            if (m_streak == THR) begin
                m_flag = 1; m_acked = 0;
                if (m_count < 255) m_count++;
                sb.push_back({2'(m_src), m_start});
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic cyc(input logic [3:0] b, input logic c, input logic r);
        block_in = b; clr = c; report_ready = r;
        @(posedge clock);
        model_edge(b, c, r);
        #1;
    endtask

    // Monitor: per-cycle control outputs plus scoreboard pop on each handshake.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("deadlock", 64'(deadlock), 64'(m_flag));
            chk("report_valid", 64'(report_valid), 64'(m_flag && !m_acked));
            chk("deadlock_count", 64'(deadlock_count), 64'(m_count));
            if (report_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL report_unexpected: got %0h expected none", report_data);
                end else begin
                    chk("report_data", 64'(report_data), 64'(sb[0]));
                    if (report_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("rst_deadlock", 64'(deadlock), 0);
        chk("rst_valid", 64'(report_valid), 0);
        chk("rst_data", 64'(report_data), 0);
        chk("rst_count", 64'(deadlock_count), 0);
        #19 reset = 1'b1;
        chk_en = 1;

        // Basic detection: bit 2 first sampled at ts 10, backpressured report.
        while (m_ts != 32'd10) cyc(4'b0000, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(4'b0100, 0, 0);
            if (i == 15) chk("basic_not_yet", 64'(report_valid), 0);
            if (i == 16) begin
                chk("basic_valid", 64'(report_valid), 1);
                chk("basic_data", 64'(report_data), 64'({2'd2, 32'd10}));
                chk("basic_count", 64'(deadlock_count), 1);
            end
        end
        cyc(4'b0100, 0, 1);
        chk("hs_valid_drop", 64'(report_valid), 0);
        chk("hs_deadlock_held", 64'(deadlock), 1);
        cyc(4'b0000, 1, 0);
        chk("clr_deadlock", 64'(deadlock), 0);

        // Glitch rejection: 15-cycle block.
        repeat (15) cyc(4'b0010, 0, 0);
        cyc(4'b0000, 0, 0);
        chk("glitch_count", 64'(deadlock_count), 1);

        // Priority: bits 1 and 3 together, then bit 1 alone; clr coincident with handshake.
        cyc(4'b1010, 0, 0);
        repeat (15) cyc(4'b0010, 0, 0);
        chk("prio_src", 64'(report_data[33:32]), 1);
        cyc(4'b0000, 1, 1);
        chk("clr_hs_count", 64'(deadlock_count), 2);
        chk("clr_hs_deadlock", 64'(deadlock), 0);

        // Bit 1 drops early while bit 3 stays: re-detect on source 3.
        repeat (5) cyc(4'b1010, 0, 0);
        repeat (17) cyc(4'b1000, 0, 0);
        chk("redetect_src", 64'(report_data[33:32]), 3);
        cyc(4'b0000, 1, 0);

        // clr mid-suspect, held block reports 16 edges after clr.
        repeat (8) cyc(4'b0001, 0, 0);
        cyc(4'b0001, 1, 0);
        repeat (15) cyc(4'b0001, 0, 0);
        chk("clr_sus_early", 64'(report_valid), 0);
        cyc(4'b0001, 0, 0);
        chk("clr_sus_report", 64'(report_valid), 1);
        cyc(4'b0000, 1, 0);

        // Randomized episodes.
        repeat (150) begin
            logic [3:0] b;
            int len;
            b   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            len = $urandom_range(1, 24);
            repeat (len) cyc(b, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
        end
        cyc(4'b0000, 1, 0);

        // Asynchronous reset during REPORT.
        repeat (16) cyc(4'b0001, 0, 0);
        chk("pre_rst_valid", 64'(report_valid), 1);
        chk_en = 0;
        block_in = '0;
        #2 reset = 1'b0;
        #1;
        chk("arst_deadlock", 64'(deadlock), 0);
        chk("arst_valid", 64'(report_valid), 0);
        chk("arst_data", 64'(report_data), 0);
        chk("arst_count", 64'(deadlock_count), 0);
        #3 reset = 1'b1;
        model_reset();
        chk_en = 1;

        // Saturation of deadlock_count.
        repeat (300) begin
            repeat (16) cyc(4'b0001, 0, 0);
            cyc(4'b0000, 1, 0);
        end
        chk("sat_count", 64'(deadlock_count), 255);
        cyc(4'b0000, 0, 0);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
